// File: rtl/inst_decode_stage.sv
// rtl/inst_decode_stage.sv - RISC-V instruction decode stage with a 2-entry output buffer
package inst_decode_pkg;
    localparam int XLEN = 64;

    typedef enum logic [2:0] {
        INST_R = 3'd0,
        INST_I = 3'd1,
        INST_S = 3'd2,
        INST_B = 3'd3,
        INST_U = 3'd4,
        INST_J = 3'd5,
        INST_X = 3'd6
    } itype_t;

    typedef struct packed {
        itype_t     itype;
        logic       rwb_en;
        logic       is_lui;
        logic       is_muldiv;
        logic       is_aluop;
        logic       is_op32;
        logic       is_jump;
        logic       is_load;
        logic       is_csr;
        logic       is_amo;
        logic       is_rvc;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } inst_ctrl_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] value;
    } expt_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [31:0]     bits;
        inst_ctrl_t      ctrl;
        logic [XLEN-1:0] imm;
        expt_t           expt;
    } entry_t;

    localparam int CTRL_W = $bits(inst_ctrl_t);
    localparam int EXPT_W = $bits(expt_t);

    localparam logic [XLEN-1:0] CAUSE_ILLEGAL_INSTR = 64'd2;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP32      = 7'b0111011;
    localparam logic [6:0] OPC_AMO       = 7'b0101111;
    localparam logic [6:0] OPC_OPIMM     = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32   = 7'b0011011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_MISCMEM   = 7'b0001111;
endpackage

module inst_decode_stage
    import inst_decode_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [XLEN-1:0]   if_addr,
    input  logic [31:0]       if_bits,
    input  logic              if_is_rvc,
    input  logic              flush,
    output logic              d_valid,
    input  logic              d_ready,
    output logic [XLEN-1:0]   d_addr,
    output logic [31:0]       d_bits,
    output logic [CTRL_W-1:0] d_ctrl,
    output logic [XLEN-1:0]   d_imm,
    output logic [EXPT_W-1:0] d_expt
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    inst_ctrl_t      dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    expt_t           dec_expt;
    entry_t          dec_entry;

    // slot0 is always the head; slot1 only holds data when count == 2
    entry_t          slot0, slot1;
    entry_t          slot0_next, slot1_next;
    logic [1:0]      count, count_next, fill;
    logic            push, pop;

    assign opcode = if_bits[6:0];
    assign funct3 = if_bits[14:12];
    assign funct7 = if_bits[31:25];

    assign imm_i = {{52{if_bits[31]}}, if_bits[31:20]};
    assign imm_s = {{52{if_bits[31]}}, if_bits[31:25], if_bits[11:7]};
    assign imm_b = {{51{if_bits[31]}}, if_bits[31], if_bits[7], if_bits[30:25], if_bits[11:8], 1'b0};
    assign imm_u = {{32{if_bits[31]}}, if_bits[31:12], 12'b0};
    assign imm_j = {{43{if_bits[31]}}, if_bits[31], if_bits[19:12], if_bits[20], if_bits[30:21], 1'b0};

    // Combinational decode of the offered instruction; unknown opcodes become illegal-instruction exceptions
    always_comb begin
        dec_ctrl        = '0;
        dec_imm         = '0;
        dec_expt        = '0;
        dec_ctrl.funct3 = funct3;
        dec_ctrl.funct7 = funct7;
        dec_ctrl.is_rvc = if_is_rvc;
        case (opcode)
            OPC_OP, OPC_OP32: begin
                dec_ctrl.itype     = INST_R;
                dec_ctrl.rwb_en    = 1'b1;
                dec_ctrl.is_muldiv = (funct7 == 7'b0000001);
                dec_ctrl.is_aluop  = (funct7 != 7'b0000001);
                dec_ctrl.is_op32   = (opcode == OPC_OP32);
            end
            OPC_AMO: begin
                dec_ctrl.itype  = INST_R;
                dec_ctrl.rwb_en = 1'b1;
                dec_ctrl.is_amo = 1'b1;
            end
            OPC_OPIMM, OPC_OPIMM32: begin
                dec_ctrl.itype    = INST_I;
                dec_ctrl.rwb_en   = 1'b1;
                dec_ctrl.is_aluop = 1'b1;
                dec_ctrl.is_op32  = (opcode == OPC_OPIMM32);
                dec_imm           = imm_i;
            end
            OPC_LOAD: begin
                dec_ctrl.itype   = INST_I;
                dec_ctrl.rwb_en  = 1'b1;
                dec_ctrl.is_load = 1'b1;
                dec_imm          = imm_i;
            end
            OPC_JALR: begin
                dec_ctrl.itype   = INST_I;
                dec_ctrl.rwb_en  = 1'b1;
                dec_ctrl.is_jump = 1'b1;
                dec_imm          = imm_i;
            end
            OPC_SYSTEM: begin
                // ecall/ebreak/xret (funct3 == 0) write no register; CSR ops do
                dec_ctrl.itype  = INST_I;
                dec_ctrl.rwb_en = (funct3 != 3'b000);
                dec_ctrl.is_csr = (funct3 != 3'b000);
                dec_imm         = imm_i;
            end
            OPC_STORE: begin
                dec_ctrl.itype = INST_S;
                dec_imm        = imm_s;
            end
            OPC_BRANCH: begin
                dec_ctrl.itype = INST_B;
                dec_imm        = imm_b;
            end
            OPC_LUI: begin
                dec_ctrl.itype  = INST_U;
                dec_ctrl.rwb_en = 1'b1;
                dec_ctrl.is_lui = 1'b1;
                dec_imm         = imm_u;
            end
            OPC_AUIPC: begin
                dec_ctrl.itype  = INST_U;
                dec_ctrl.rwb_en = 1'b1;
                dec_imm         = imm_u;
            end
            OPC_JAL: begin
                dec_ctrl.itype   = INST_J;
                dec_ctrl.rwb_en  = 1'b1;
                dec_ctrl.is_jump = 1'b1;
                dec_imm          = imm_j;
            end
            OPC_MISCMEM: begin
                dec_ctrl.itype = INST_X;
            end
            default: begin
                dec_ctrl.itype = INST_X;
                dec_expt.valid = 1'b1;
                dec_expt.cause = CAUSE_ILLEGAL_INSTR;
                dec_expt.value = {32'b0, if_bits};
            end
        endcase
    end

    assign dec_entry = '{addr: if_addr, bits: if_bits, ctrl: dec_ctrl, imm: dec_imm, expt: dec_expt};

    assign d_valid = (count != 2'd0);
    assign push    = if_valid && if_ready && !flush;
    assign pop     = d_valid && d_ready && !flush;
    assign fill    = count - {1'b0, pop};

    // Buffer next state: pop shifts slot1 into the head, push lands in the first free slot after the pop
    always_comb begin
        slot0_next = slot0;
        slot1_next = slot1;
        count_next = flush ? 2'd0 : (count + {1'b0, push} - {1'b0, pop});
        if (pop) begin
            slot0_next = slot1;
        end
        if (push) begin
            if (fill == 2'd0) begin
                slot0_next = dec_entry;
            end else begin
                slot1_next = dec_entry;
            end
        end
    end

    // State registers; reset clears everything so the head outputs read as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= 2'd0;
            if_ready <= 1'b1;
            slot0    <= '0;
            slot1    <= '0;
        end else begin
            count    <= count_next;
            if_ready <= (count_next < 2'd2);
            slot0    <= slot0_next;
            slot1    <= slot1_next;
        end
    end

    assign d_addr = slot0.addr;
    assign d_bits = slot0.bits;
    assign d_ctrl = slot0.ctrl;
    assign d_imm  = slot0.imm;
    assign d_expt = slot0.expt;

endmodule

// File: tb/tb_inst_decode_stage.sv
// tb/tb_inst_decode_stage.sv - randomized and directed checks of inst_decode_stage against a queue model
module tb_inst_decode_stage;
    import inst_decode_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_valid = 1'b0;
    logic              if_ready;
    logic [63:0]       if_addr = '0;
    logic [31:0]       if_bits = '0;
    logic              if_is_rvc = 1'b0;
    logic              flush = 1'b0;
    logic              d_valid;
    logic              d_ready = 1'b0;
    logic [63:0]       d_addr;
    logic [31:0]       d_bits;
    logic [CTRL_W-1:0] d_ctrl;
    logic [63:0]       d_imm;
    logic [EXPT_W-1:0] d_expt;

    inst_ctrl_t dc;
    expt_t      de;
    assign dc = d_ctrl;
    assign de = d_expt;

    entry_t      q[$];
    logic [31:0] obs[$];
    logic        ready_exp;
    int          n_checks = 0;
    int          n_pass = 0;

    logic [6:0] legal_ops[14] = '{7'b0110011, 7'b0111011, 7'b0101111, 7'b0010011, 7'b0011011,
                                  7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011, 7'b1100011,
                                  7'b0110111, 7'b0010111, 7'b1101111, 7'b0001111};

    inst_decode_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
        .if_bits(if_bits), .if_is_rvc(if_is_rvc), .flush(flush), .d_valid(d_valid),
        .d_ready(d_ready), .d_addr(d_addr), .d_bits(d_bits), .d_ctrl(d_ctrl),
        .d_imm(d_imm), .d_expt(d_expt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference decode written from the opcode tables and immediate bit layouts
    function automatic entry_t ref_decode(input logic [63:0] a, input logic [31:0] b, input logic r);
        entry_t             e;
        logic [6:0]         op;
        logic [2:0]         f3;
        logic signed [63:0] t;
        op = b[6:0];
        f3 = b[14:12];
        e = '0;
        e.addr = a;
        e.bits = b;
        e.ctrl.funct3 = f3;
        e.ctrl.funct7 = b[31:25];
        e.ctrl.is_rvc = r;
        if (!(op inside {legal_ops})) begin
            e.ctrl.itype = INST_X;
            e.expt.valid = 1'b1;
            e.expt.cause = 64'd2;
            e.expt.value = {32'b0, b};
            return e;
        end
        if (op inside {7'b0110011, 7'b0111011, 7'b0101111}) e.ctrl.itype = INST_R;
        else if (op inside {7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111, 7'b1110011}) e.ctrl.itype = INST_I;
        else if (op == 7'b0100011) e.ctrl.itype = INST_S;
        else if (op == 7'b1100011) e.ctrl.itype = INST_B;
        else if (op inside {7'b0110111, 7'b0010111}) e.ctrl.itype = INST_U;
        else if (op == 7'b1101111) e.ctrl.itype = INST_J;
        else e.ctrl.itype = INST_X;
        e.ctrl.is_lui    = (op == 7'b0110111);
        e.ctrl.is_muldiv = (op inside {7'b0110011, 7'b0111011}) && (b[31:25] == 7'd1);
        e.ctrl.is_aluop  = (op inside {7'b0110011, 7'b0010011, 7'b0111011, 7'b0011011}) && !e.ctrl.is_muldiv;
        e.ctrl.is_op32   = (op inside {7'b0111011, 7'b0011011});
        e.ctrl.is_jump   = (op inside {7'b1101111, 7'b1100111});
        e.ctrl.is_load   = (op == 7'b0000011);
        e.ctrl.is_csr    = (op == 7'b1110011) && (f3 != 3'd0);
        e.ctrl.is_amo    = (op == 7'b0101111);
        e.ctrl.rwb_en    = (e.ctrl.itype inside {INST_R, INST_I, INST_U, INST_J})
                           && !((op == 7'b1110011) && (f3 == 3'd0));
        // Place the immediate field at the top of a signed word and arithmetic-shift it down
        case (e.ctrl.itype)
            INST_I:  begin t = {b[31:20], 52'b0};                                   e.imm = t >>> 52; end
            INST_S:  begin t = {b[31:25], b[11:7], 52'b0};                          e.imm = t >>> 52; end
            INST_B:  begin t = {b[31], b[7], b[30:25], b[11:8], 1'b0, 51'b0};       e.imm = t >>> 51; end
            INST_U:  begin t = {b[31:12], 12'b0, 32'b0};                            e.imm = t >>> 32; end
            INST_J:  begin t = {b[31], b[19:12], b[20], b[30:21], 1'b0, 43'b0};     e.imm = t >>> 43; end
            default: e.imm = '0;
        endcase
        return e;
    endfunction

    task automatic check_outputs();
        check("d_valid", d_valid, q.size() > 0);
        check("if_ready", if_ready, ready_exp);
        if (q.size() > 0) begin
            check("d_addr", d_addr, q[0].addr);
            check("d_bits", d_bits, q[0].bits);
            check("d_ctrl", d_ctrl, q[0].ctrl);
            check("d_imm", d_imm, q[0].imm);
            check("d_expt", d_expt, q[0].expt);
        end
    endtask

    // Called at a falling edge: drive one cycle of inputs, advance the model, check at the next falling edge
    task automatic cycle(input logic v, input logic [63:0] a, input logic [31:0] b, input logic r,
                         input logic dr, input logic fl, output logic acc);
        logic do_push, do_pop;
        if_valid = v; if_addr = a; if_bits = b; if_is_rvc = r; d_ready = dr; flush = fl;
        do_push = v && ready_exp && !fl;
        do_pop  = (q.size() > 0) && dr && !fl;
        if (d_valid && dr && !fl) obs.push_back(d_bits);
        if (fl) q.delete();
        else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(ref_decode(a, b, r));
        end
        ready_exp = (q.size() < 2);
        acc = do_push;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input logic dr);
        logic acc;
        cycle(1'b0, 64'd0, 32'd0, 1'b0, dr, 1'b0, acc);
    endtask

    initial begin
        logic        acc, c_done;
        logic [31:0] rb;
        ready_exp = 1'b1;

        #1 rst = 1'b1;
        #2;
        check("rst_d_valid", d_valid, 1'b0);
        check("rst_if_ready", if_ready, 1'b1);
        check("rst_d_ctrl", d_ctrl, '0);
        check("rst_d_imm", d_imm, '0);
        check("rst_d_expt", d_expt, '0);
        check("rst_d_addr", d_addr, '0);
        check("rst_d_bits", d_bits, '0);
        @(negedge clk);
        rst = 1'b0;

        cycle(1'b1, 64'h80000000, 32'h00500093, 1'b0, 1'b1, 1'b0, acc);
        check("addi_valid", d_valid, 1'b1);
        check("addi_itype", dc.itype, INST_I);
        check("addi_rwb", dc.rwb_en, 1'b1);
        check("addi_aluop", dc.is_aluop, 1'b1);
        check("addi_imm", d_imm, 64'd5);
        check("addi_addr", d_addr, 64'h80000000);

        cycle(1'b1, 64'h80000004, 32'hFE000EE3, 1'b0, 1'b1, 1'b0, acc);
        check("beq_itype", dc.itype, INST_B);
        check("beq_rwb", dc.rwb_en, 1'b0);
        check("beq_imm", d_imm, 64'hFFFFFFFFFFFFFFFC);

        cycle(1'b1, 64'h80000008, 32'h022081B3, 1'b0, 1'b1, 1'b0, acc);
        check("mul_itype", dc.itype, INST_R);
        check("mul_muldiv", dc.is_muldiv, 1'b1);
        check("mul_aluop", dc.is_aluop, 1'b0);
        check("mul_funct7", dc.funct7, 7'b0000001);

        cycle(1'b1, 64'h8000000C, 32'h00000000, 1'b1, 1'b1, 1'b0, acc);
        check("ill_valid", de.valid, 1'b1);
        check("ill_cause", de.cause, 64'd2);
        check("ill_value", de.value, 64'd0);
        check("ill_rwb", dc.rwb_en, 1'b0);
        check("ill_itype", dc.itype, INST_X);
        check("ill_rvc", dc.is_rvc, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: A and B fill the buffer, C waits until space frees up
        obs.delete();
        cycle(1'b1, 64'h100, 32'h00100093, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 64'h104, 32'h00200113, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 64'h108, 32'h00300193, 1'b0, 1'b0, 1'b0, acc);
        check("bp_c_held", acc, 1'b0);
        check("bp_if_ready", if_ready, 1'b0);
        c_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(!c_done, 64'h108, 32'h00300193, 1'b0, 1'b1, 1'b0, acc);
            if (acc) c_done = 1'b1;
        end
        check("bp_c_accepted", c_done, 1'b1);
        check("bp_count", obs.size(), 3);
        if (obs.size() == 3) begin
            check("bp_order_a", obs[0], 32'h00100093);
            check("bp_order_b", obs[1], 32'h00200113);
            check("bp_order_c", obs[2], 32'h00300193);
        end

        // Flush with two entries held, an offer and a d_ready in the same cycle
        cycle(1'b1, 64'h200, 32'h00000013, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 64'h204, 32'h00000033, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 64'h208, 32'h00000093, 1'b0, 1'b1, 1'b1, acc);
        check("flush_d_valid", d_valid, 1'b0);
        check("flush_if_ready", if_ready, 1'b1);
        idle(1'b1);

        // Asynchronous reset in the middle of a cycle with entries held
        cycle(1'b1, 64'h300, 32'h123450B7, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 64'h304, 32'h0000006F, 1'b0, 1'b0, 1'b0, acc);
        #2 rst = 1'b1;
        #1;
        check("arst_d_valid", d_valid, 1'b0);
        check("arst_if_ready", if_ready, 1'b1);
        check("arst_d_bits", d_bits, '0);
        check("arst_d_ctrl", d_ctrl, '0);
        q.delete();
        ready_exp = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if_valid = 1'b0;
        d_ready = 1'b0;
        cycle(1'b1, 64'h400, 32'h00500093, 1'b0, 1'b0, 1'b0, acc);
        check("post_rst_valid", d_valid, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            rb = $urandom;
            if ($urandom_range(0, 9) < 8) rb[6:0] = legal_ops[$urandom_range(0, 13)];
            if ($urandom_range(0, 3) == 0) rb[31:25] = 7'd1;
            if ($urandom_range(0, 5) == 0) rb[14:12] = 3'd0;
            cycle($urandom_range(0, 3) != 0, {$urandom, $urandom}, rb, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, acc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
